seq_detect_ctrl: RTL and testbench
==================================

# seq_detect_ctrl

Programmable serial pattern-detection controller for the sequence-detector datapath. It accepts a runtime pattern of 1..MAX_LEN bits through a valid/ready configuration port and arms or disarms detection on a bit-serial input. It produces a Mealy match pulse in overlapping or non-overlapping mode, keeps a saturating match count, and optionally raises a sticky interrupt. It replaces per-pattern hard-coded Mealy FSMs with one configurable block.

## Interface
- MAX_LEN, 8: maximum pattern length in bits (2..16)
- CNT_W, 8: match counter width
- LEN_W, $clog2(MAX_LEN)+1: width of cfg_len (derived; not overridden)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; asynchronous and active-low
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  high only in IDLE
- cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected
- cfg_len  in  LEN_W  pattern length; legal range 1..MAX_LEN
- cfg_overlap  in  1  1 = overlapping detection, 0 = non-overlapping
- cfg_err  out  1  one-cycle pulse when a configuration is rejected
- arm  in  1  level; high requests detection
- in  in  1  serial data bit
- in_valid  in  1  qualifies in
- out  out  1  Mealy match pulse
- match_cnt  out  CNT_W  saturating match count
- irq  out  1  sticky match interrupt
- irq_clr  in  1  clears irq

## Operation
- FSM states:
  - IDLE: unarmed.
  - ARMED: detecting.
- IDLE→ARMED: arm=1 and cfg_ok=1. A config accepted in the same cycle takes effect first.
- ARMED→IDLE: arm=0. Entering ARMED clears the bit history.
- Config handshake:
  - Accepted when cfg_valid & cfg_ready.
  - cfg_len==0 or cfg_len>MAX_LEN: registers are unchanged, cfg_err pulses for 1 cycle.
  - Legal config: pattern, len and overlap are latched, cfg_ok=1, history cleared, match_cnt cleared.
- Datapath:
  - hist is a MAX_LEN-1 bit shift register. hcnt counts valid bits since the last clear, saturating at MAX_LEN-1.
  - On ARMED & in_valid: hist <= {hist, in}, and hcnt increments.
  - out = ARMED & in_valid & (hcnt ≥ len-1) & ({hist[len-2:0], in} == pattern[len-1:0]).
  - For len==1: out = ARMED & in_valid & (in == pattern[0]).
- Overlap rule:
  - cfg_overlap=1: history keeps shifting after a match.
  - cfg_overlap=0: on a match, hcnt and hist clear at the edge, so the next match needs len fresh bits.
- match_cnt increments on every out=1 and saturates at 2^CNT_W-1, never wrapping.
- Bits arriving while IDLE or with in_valid=0 are ignored, and history is held.

## Timing
- out is combinational, asserted in the same cycle as the final pattern bit: zero latency.
- match_cnt, irq and hist update on the rising clk edge after out.
- Reset values: cfg_ready=1, cfg_err=0, out=0, match_cnt=0, irq=0, state=IDLE, cfg_ok=0, pattern=0, len=0, hist=0, hcnt=0.
- rst low mid-stream: everything returns to reset values immediately (asynchronous). cfg_ok=0, so a reconfiguration is required before arming.
- arm deasserted in the same cycle as a match: out still asserts that cycle, and the count updates.
- irq_clr and a match in the same cycle: irq stays 1, because set wins.

## Configuration
- SEQ_DETECT_IRQ_EN defined: irq is set on the edge after any out=1 and cleared by irq_clr.
- SEQ_DETECT_IRQ_EN not defined: no irq logic is built, irq is tied to 0, and irq_clr is ignored.

## Structure
- Shared package seq_detect_pkg holds:
  - state enum {IDLE, ARMED};
  - MAX_LEN_DEFAULT and CNT_W_DEFAULT constants;
  - a cfg struct {pattern, len, overlap}.
- One sub-module, seq_match_core, contains hist, hcnt and the masked compare. It outputs the combinational hit.
- The top-level block contains the FSM, config handshake, counter and irq.

## Test plan
- Config pattern 4'b1101, len 4, overlap=1, arm, stream 0,1,0,1,1,0,1,1,0,1,1,0,1,1 -> out=1 on bits 7, 10 and 13; match_cnt=3.
- Same stream with overlap=0 -> out=1 on bits 7 and 13 only; match_cnt=2.
- Pattern 2'b11, len 2, stream 1,1,1,1 -> overlap=1 gives 3 pulses; overlap=0 gives 2 pulses.
- Configuration checks:
  - cfg_len=0 -> cfg_err pulses 1 cycle, cfg_ok stays 0, and arm does not leave IDLE.
  - cfg_len=MAX_LEN+1 -> same as cfg_len=0.
  - cfg_valid while ARMED -> not accepted, because cfg_ready=0.
- CNT_W=2, 5 matches -> match_cnt saturates at 3.
- Reset and irq:
  - Pull rst low after 3 of 4 pattern bits -> all outputs go to reset values; after reconfig and re-arm, no match occurs until 4 fresh bits arrive.
  - With SEQ_DETECT_IRQ_EN: irq rises after the first match; irq_clr on a non-match cycle clears it; irq_clr coincident with a match leaves irq=1.

Source files
------------

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern-detection controller.
// Optional sticky interrupt is enabled by defining SEQ_DETECT_IRQ_EN.
package seq_detect_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam int MAX_LEN_DEFAULT = 8;
    localparam int CNT_W_DEFAULT   = 8;

    // Storage is sized for the largest supported pattern so one type serves every MAX_LEN
    localparam int PAT_W       = 16;
    localparam int LEN_FIELD_W = 5;

    typedef struct packed {
        logic [PAT_W-1:0]       pattern;
        logic [LEN_FIELD_W-1:0] len;
        logic                   overlap;
    } cfg_t;

    function automatic logic cfg_len_legal(input logic [LEN_FIELD_W-1:0] len, input int max_len);
        return (len != '0) && (int'(len) <= max_len);
    endfunction

endpackage

// File: rtl/seq_match_core.sv
// Bit history, valid-bit counter and length-masked compare; hit_o is combinational.
// A non-overlapping hit discards the history so the next match needs len fresh bits.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic shift_i,
    input  logic bit_i,
    input  cfg_t cfg_i,
    output logic hit_o
);

    localparam logic [LEN_FIELD_W-1:0] HCNT_MAX = LEN_FIELD_W'(MAX_LEN - 1);

    logic [MAX_LEN-2:0]     hist_q, hist_d;
    logic [LEN_FIELD_W-1:0] hcnt_q, hcnt_d;
    logic [MAX_LEN-1:0]     window;
    logic [PAT_W-1:0]       window_ext;
    logic [PAT_W-1:0]       len_mask;
    logic                   enough_bits;
    logic                   pattern_eq;

    assign window     = {hist_q, bit_i};
    assign window_ext = PAT_W'(window);

    generate
        for (genvar gi = 0; gi < PAT_W; gi++) begin : g_mask
            assign len_mask[gi] = (cfg_i.len > LEN_FIELD_W'(gi));
        end
    endgenerate

    // hcnt + 1 >= len, widened so len == 0 cannot underflow
    assign enough_bits = ({1'b0, hcnt_q} + 6'd1) >= {1'b0, cfg_i.len};
    assign pattern_eq  = ((window_ext ^ cfg_i.pattern) & len_mask) == '0;
    assign hit_o       = shift_i & enough_bits & pattern_eq;

    always_comb begin
        hist_d = hist_q;
        hcnt_d = hcnt_q;
        if (clear_i) begin
            hist_d = '0;
            hcnt_d = '0;
        end else if (shift_i) begin
            if (hit_o && !cfg_i.overlap) begin
                hist_d = '0;
                hcnt_d = '0;
            end else begin
                hist_d = window[MAX_LEN-2:0];
                if (hcnt_q != HCNT_MAX) begin
                    hcnt_d = hcnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            hcnt_q <= '0;
        end else begin
            hist_q <= hist_d;
            hcnt_q <= hcnt_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detector: config handshake, arm FSM, saturating match count.
// Define SEQ_DETECT_IRQ_EN to build the sticky match interrupt; otherwise irq is tied low.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT,
    parameter int LEN_W   = $clog2(MAX_LEN) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [MAX_LEN-1:0] cfg_pattern,
    input  logic [LEN_W-1:0]   cfg_len,
    input  logic               cfg_overlap,
    output logic               cfg_err,
    input  logic               arm,
    input  logic               in,
    input  logic               in_valid,
    output logic               out,
    output logic [CNT_W-1:0]   match_cnt,
    output logic               irq,
    input  logic               irq_clr
);

    state_e           state_q;
    cfg_t             cfg_q;
    logic             cfg_ok_q;
    logic             cfg_ok_d;
    logic             cfg_err_q;
    logic [CNT_W-1:0] match_cnt_q;

    logic cfg_fire;
    logic cfg_legal;
    logic cfg_load;
    logic arm_go;
    logic shift;
    logic hit;

    assign cfg_fire  = cfg_valid && (state_q == IDLE);
    assign cfg_legal = cfg_len_legal(LEN_FIELD_W'(cfg_len), MAX_LEN);
    assign cfg_load  = cfg_fire && cfg_legal;
    // A config accepted this cycle already counts towards arming
    assign cfg_ok_d  = cfg_ok_q || cfg_load;
    assign arm_go    = (state_q == IDLE) && arm && cfg_ok_d;
    assign shift     = (state_q == ARMED) && in_valid;

    seq_match_core #(
        .MAX_LEN (MAX_LEN)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clear_i (cfg_load || arm_go),
        .shift_i (shift),
        .bit_i   (in),
        .cfg_i   (cfg_q),
        .hit_o   (hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            cfg_ok_q    <= 1'b0;
            cfg_err_q   <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            cfg_err_q <= cfg_fire && !cfg_legal;
            cfg_ok_q  <= cfg_ok_d;
            if (cfg_load) begin
                cfg_q.pattern <= PAT_W'(cfg_pattern);
                cfg_q.len     <= LEN_FIELD_W'(cfg_len);
                cfg_q.overlap <= cfg_overlap;
            end

            case (state_q)
                IDLE:    if (arm_go) state_q <= ARMED;
                ARMED:   if (!arm)   state_q <= IDLE;
                default:             state_q <= IDLE;
            endcase

            if (cfg_load) begin
                match_cnt_q <= '0;
            end else if (hit && (match_cnt_q != '1)) begin
                match_cnt_q <= match_cnt_q + 1'b1;
            end
        end
    end

`ifdef SEQ_DETECT_IRQ_EN
    logic irq_q;

    // Set has priority over clear
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq_q <= 1'b0;
        end else if (hit) begin
            irq_q <= 1'b1;
        end else if (irq_clr) begin
            irq_q <= 1'b0;
        end
    end

    assign irq = irq_q;
`else
    logic unused_irq_clr;

    assign unused_irq_clr = irq_clr;
    assign irq            = 1'b0;
`endif

    assign cfg_ready = (state_q == IDLE);
    assign cfg_err   = cfg_err_q;
    assign out       = hit;
    assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed bench for seq_detect_ctrl: a default instance plus a CNT_W=2 instance for saturation.
module tb_seq_detect_ctrl;

`ifdef SEQ_DETECT_IRQ_EN
    localparam logic IRQ_ON = 1'b1;
`else
    localparam logic IRQ_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cfg_valid = 1'b0;
    logic [7:0] cfg_pattern = '0;
    logic [3:0] cfg_len = '0;
    logic       cfg_overlap = 1'b0;
    logic       arm = 1'b1;
    logic       in_bit = 1'b1;
    logic       in_valid = 1'b1;
    logic       irq_clr = 1'b0;

    logic       cfg_ready, cfg_err, out_w, irq;
    logic [7:0] match_cnt;
    logic       cfg_ready2, cfg_err2, out2, irq2;
    logic [1:0] match_cnt2;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_err(cfg_err), .arm(arm), .in(in_bit), .in_valid(in_valid),
        .out(out_w), .match_cnt(match_cnt), .irq(irq), .irq_clr(irq_clr)
    );

    seq_detect_ctrl #(.MAX_LEN(8), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready2),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_err(cfg_err2), .arm(arm), .in(in_bit), .in_valid(in_valid),
        .out(out2), .match_cnt(match_cnt2), .irq(irq2), .irq_clr(irq_clr)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic hard_reset;
        rst = 1'b0; arm = 1'b0; in_valid = 1'b0; cfg_valid = 1'b0; irq_clr = 1'b0;
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic configure(input logic [7:0] pat, input logic [3:0] len, input logic ov);
        cfg_valid = 1'b1; cfg_pattern = pat; cfg_len = len; cfg_overlap = ov;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        if (cfg_ready !== 1'b1) begin $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); n_mis++; end
        n_cmp++;
        if (cfg_err !== 1'b0) begin $display("FAIL reset_cfg_err: got %b expected 0", cfg_err); n_mis++; end
        n_cmp++;
        if (out_w !== 1'b0) begin $display("FAIL reset_out: got %b expected 0", out_w); n_mis++; end
        n_cmp++;
        if (match_cnt !== 8'd0) begin $display("FAIL reset_match_cnt: got %0d expected 0", match_cnt); n_mis++; end
        n_cmp++;
        if (irq !== 1'b0) begin $display("FAIL reset_irq: got %b expected 0", irq); n_mis++; end
        n_cmp++;
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        tick();
        if (cfg_ready !== 1'b1) begin $display("FAIL arm_without_cfg: cfg_ready got %b expected 1", cfg_ready); n_mis++; end
        n_cmp++;
        if (out_w !== 1'b0) begin $display("FAIL idle_out: got %b expected 0", out_w); n_mis++; end
        n_cmp++;
        $display("test_reset done");
        arm = 1'b0; in_valid = 1'b0;
        tick();
    endtask

    task automatic run_1101_stream(input logic ov, input logic [13:0] exp_out, input logic [7:0] exp_cnt);
        logic [13:0] stream;
        stream = 14'b01011011011011;
        configure(8'b1101, 4'd4, ov);
        arm = 1'b1;
        tick();
        if (cfg_ready !== 1'b0) begin $display("FAIL armed_cfg_ready ov=%0b: got %b expected 0", ov, cfg_ready); n_mis++; end
        n_cmp++;
        for (int i = 0; i < 14; i++) begin
            in_bit = stream[13-i]; in_valid = 1'b1;
            #1;
            if (out_w !== exp_out[13-i]) begin
                $display("FAIL stream1101 ov=%0b bit%0d: out got %b expected %b", ov, i + 1, out_w, exp_out[13-i]);
                n_mis++;
            end
            n_cmp++;
            tick();
        end
        in_valid = 1'b0;
        if (match_cnt !== exp_cnt) begin $display("FAIL stream1101_cnt ov=%0b: got %0d expected %0d", ov, match_cnt, exp_cnt); n_mis++; end
        n_cmp++;
        $display("stream 1101 ov=%0b done, match_cnt=%0d", ov, match_cnt);
        arm = 1'b0;
        tick();
    endtask

    task automatic test_overlap;
        hard_reset();
        run_1101_stream(1'b1, 14'b00000010010010, 8'd3);
    endtask

    task automatic test_non_overlap;
        run_1101_stream(1'b0, 14'b00000010000010, 8'd2);
    endtask

    task automatic test_len2_arm_drop;
        logic [3:0] exp_out;
        logic [7:0] exp_cnt;
        for (int k = 0; k < 2; k++) begin
            logic ov;
            ov      = (k == 0);
            exp_out = ov ? 4'b0111 : 4'b0101;
            exp_cnt = ov ? 8'd3 : 8'd2;
            configure(8'b11, 4'd2, ov);
            arm = 1'b1;
            tick();
            for (int i = 0; i < 4; i++) begin
                in_bit = 1'b1; in_valid = 1'b1;
                if (i == 3) arm = 1'b0;
                #1;
                if (out_w !== exp_out[3-i]) begin
                    $display("FAIL len2 ov=%0b bit%0d: out got %b expected %b", ov, i + 1, out_w, exp_out[3-i]);
                    n_mis++;
                end
                n_cmp++;
                tick();
            end
            in_valid = 1'b0;
            if (match_cnt !== exp_cnt) begin $display("FAIL len2_cnt ov=%0b: got %0d expected %0d", ov, match_cnt, exp_cnt); n_mis++; end
            n_cmp++;
            if (cfg_ready !== 1'b1) begin $display("FAIL len2_disarm ov=%0b: cfg_ready got %b expected 1", ov, cfg_ready); n_mis++; end
            n_cmp++;
            $display("len2 ov=%0b done, match_cnt=%0d", ov, match_cnt);
        end
    endtask

    task automatic test_cfg_err;
        logic [3:0] bad_len [2];
        bad_len[0] = 4'd0;
        bad_len[1] = 4'd9;
        hard_reset();
        for (int k = 0; k < 2; k++) begin
            configure(8'b11, bad_len[k], 1'b1);
            if (cfg_err !== 1'b1) begin $display("FAIL cfg_err_pulse len=%0d: got %b expected 1", bad_len[k], cfg_err); n_mis++; end
            n_cmp++;
            arm = 1'b1;
            tick();
            if (cfg_err !== 1'b0) begin $display("FAIL cfg_err_width len=%0d: got %b expected 0", bad_len[k], cfg_err); n_mis++; end
            n_cmp++;
            tick();
            if (cfg_ready !== 1'b1) begin $display("FAIL bad_cfg_armed len=%0d: cfg_ready got %b expected 1", bad_len[k], cfg_ready); n_mis++; end
            n_cmp++;
            arm = 1'b0;
            $display("cfg len=%0d rejected", bad_len[k]);
        end
        arm = 1'b1;
        configure(8'b11, 4'd2, 1'b1);
        if (cfg_ready !== 1'b0) begin $display("FAIL cfg_and_arm: cfg_ready got %b expected 0", cfg_ready); n_mis++; end
        n_cmp++;
        configure(8'b00, 4'd0, 1'b1);
        if (cfg_err !== 1'b0) begin $display("FAIL armed_bad_cfg: cfg_err got %b expected 0", cfg_err); n_mis++; end
        n_cmp++;
        configure(8'b00, 4'd2, 1'b1);
        for (int i = 0; i < 2; i++) begin
            in_bit = 1'b1; in_valid = 1'b1;
            #1;
            if (out_w !== (i == 1)) begin $display("FAIL armed_cfg_ignored bit%0d: out got %b expected %b", i + 1, out_w, (i == 1)); n_mis++; end
            n_cmp++;
            tick();
        end
        in_valid = 1'b0;
        if (match_cnt !== 8'd1) begin $display("FAIL armed_cfg_cnt: got %0d expected 1", match_cnt); n_mis++; end
        n_cmp++;
        $display("armed config ignored, match_cnt=%0d", match_cnt);
        arm = 1'b0;
        tick();
    endtask

    task automatic test_saturation;
        logic [5:0] exp_out;
        exp_out = 6'b011111;
        hard_reset();
        configure(8'b11, 4'd2, 1'b1);
        arm = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            in_bit = 1'b1; in_valid = 1'b1;
            #1;
            if (out2 !== exp_out[5-i]) begin $display("FAIL sat_out bit%0d: got %b expected %b", i + 1, out2, exp_out[5-i]); n_mis++; end
            n_cmp++;
            tick();
        end
        in_valid = 1'b0;
        if (match_cnt !== 8'd5) begin $display("FAIL sat_wide_cnt: got %0d expected 5", match_cnt); n_mis++; end
        n_cmp++;
        if (match_cnt2 !== 2'd3) begin $display("FAIL sat_narrow_cnt: got %0d expected 3", match_cnt2); n_mis++; end
        n_cmp++;
        $display("saturation: wide=%0d narrow=%0d", match_cnt, match_cnt2);
        arm = 1'b0;
        tick();
    endtask

    task automatic test_reset_midstream;
        logic [6:0] pre_stream;
        logic [6:0] pre_exp;
        logic [3:0] post_stream;
        logic [3:0] post_exp;
        pre_stream  = 7'b1101110;
        pre_exp     = 7'b0001000;
        post_stream = 4'b1101;
        post_exp    = 4'b0001;
        hard_reset();
        configure(8'b1101, 4'd4, 1'b1);
        arm = 1'b1;
        tick();
        for (int i = 0; i < 7; i++) begin
            in_bit = pre_stream[6-i]; in_valid = 1'b1;
            #1;
            if (out_w !== pre_exp[6-i]) begin $display("FAIL midrst_pre bit%0d: out got %b expected %b", i + 1, out_w, pre_exp[6-i]); n_mis++; end
            n_cmp++;
            tick();
        end
        in_bit = 1'b1; in_valid = 1'b1;
        #1;
        if (out_w !== 1'b1) begin $display("FAIL midrst_pending: out got %b expected 1", out_w); n_mis++; end
        n_cmp++;
        rst = 1'b0;
        #1;
        if (out_w !== 1'b0) begin $display("FAIL midrst_out: got %b expected 0", out_w); n_mis++; end
        n_cmp++;
        if (match_cnt !== 8'd0) begin $display("FAIL midrst_cnt: got %0d expected 0", match_cnt); n_mis++; end
        n_cmp++;
        if (cfg_ready !== 1'b1) begin $display("FAIL midrst_cfg_ready: got %b expected 1", cfg_ready); n_mis++; end
        n_cmp++;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        tick();
        if (cfg_ready !== 1'b1) begin $display("FAIL midrst_needs_cfg: cfg_ready got %b expected 1", cfg_ready); n_mis++; end
        n_cmp++;
        configure(8'b1101, 4'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            in_bit = post_stream[3-i]; in_valid = 1'b1;
            #1;
            if (out_w !== post_exp[3-i]) begin $display("FAIL midrst_post bit%0d: out got %b expected %b", i + 1, out_w, post_exp[3-i]); n_mis++; end
            n_cmp++;
            tick();
        end
        in_valid = 1'b0;
        if (match_cnt !== 8'd1) begin $display("FAIL midrst_post_cnt: got %0d expected 1", match_cnt); n_mis++; end
        n_cmp++;
        $display("mid-stream reset recovered, match_cnt=%0d", match_cnt);
        arm = 1'b0;
        tick();
    endtask

    task automatic test_irq;
        logic [4:0] v_seq;
        logic [4:0] clr_seq;
        logic [4:0] exp_out;
        logic [4:0] exp_irq;
        v_seq   = 5'b11010;
        clr_seq = 5'b00110;
        exp_out = 5'b01010;
        exp_irq = {1'b0, IRQ_ON, 1'b0, IRQ_ON, IRQ_ON};
        hard_reset();
        configure(8'b11, 4'd2, 1'b1);
        arm = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            in_bit = 1'b1; in_valid = v_seq[4-i]; irq_clr = clr_seq[4-i];
            #1;
            if (out_w !== exp_out[4-i]) begin $display("FAIL irq_out step%0d: got %b expected %b", i + 1, out_w, exp_out[4-i]); n_mis++; end
            n_cmp++;
            tick();
            if (irq !== exp_irq[4-i]) begin $display("FAIL irq step%0d: got %b expected %b", i + 1, irq, exp_irq[4-i]); n_mis++; end
            n_cmp++;
            $display("irq step%0d: out=%b irq=%b", i + 1, exp_out[4-i], irq);
        end
        in_valid = 1'b0; irq_clr = 1'b0; arm = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_len2_arm_drop();
        test_cfg_err();
        test_saturation();
        test_reset_midstream();
        test_irq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
